// File: rtl/ex_issue_stage_pkg.sv
// Shared definitions for the ID/EX issue stage: ALU/branch funct3 encodings,
// the held-entry record and the storage states.
package ex_issue_stage_pkg;

  localparam int ISSUE_XLEN    = 32;
  localparam int ISSUE_RADDR_W = 5;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_f3_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [2:0]               funct3;
    logic                     alt;
    logic                     branch;
    logic                     use_imm;
    logic                     use_pc;
    logic [ISSUE_RADDR_W-1:0] rs1_addr;
    logic [ISSUE_RADDR_W-1:0] rs2_addr;
    logic [ISSUE_XLEN-1:0]    rs1_val;
    logic [ISSUE_XLEN-1:0]    rs2_val;
    logic [ISSUE_XLEN-1:0]    imm;
    logic [ISSUE_XLEN-1:0]    pc;
    logic [ISSUE_RADDR_W-1:0] rd;
  } issue_entry_t;

  // The ALU expects the shift amount and the SLT "greater" side on op1.
  function automatic logic swap_ops(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR) || (f3 == F3_SLT) || (f3 == F3_SLTU);
  endfunction

  function automatic logic alt_allowed(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_SR);
  endfunction

endpackage

// File: rtl/ex_issue_stage_fwd_mux.sv
// Write-back forwarding select for one source operand; x0 is never forwarded.
module fwd_mux #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               i_fwd_en,
  input  logic [RADDR_W-1:0] i_fwd_rd,
  input  logic [XLEN-1:0]    i_fwd_data,
  input  logic [RADDR_W-1:0] i_rs_addr,
  input  logic [XLEN-1:0]    i_rs_val,
  output logic [XLEN-1:0]    o_rs_val
);

  logic w_hit;

  assign w_hit    = i_fwd_en && (i_fwd_rd == i_rs_addr) && (i_rs_addr != '0);
  assign o_rs_val = w_hit ? i_fwd_data : i_rs_val;

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue register: two-entry (main + skid) buffer with write-back forwarding
// on incoming and held operands, and operand ordering for the ALU.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
#(
  parameter int XLEN    = ISSUE_XLEN,
  parameter int RADDR_W = ISSUE_RADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_funct3,
  input  logic               in_alt,
  input  logic               in_branch,
  input  logic               in_use_imm,
  input  logic               in_use_pc,
  input  logic [RADDR_W-1:0] in_rs1_addr,
  input  logic [RADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]    in_rs1_val,
  input  logic [XLEN-1:0]    in_rs2_val,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               fwd_en,
  input  logic [RADDR_W-1:0] fwd_rd,
  input  logic [XLEN-1:0]    fwd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         alu_opsel,
  output logic               alu_alt,
  output logic               alu_branch,
  output logic [XLEN-1:0]    alu_op1,
  output logic [XLEN-1:0]    alu_op2,
  output logic [RADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]    out_pc
);

  issue_state_e r_state, w_state_nxt;
  logic         r_in_ready;
  issue_entry_t r_main, r_skid;
  issue_entry_t w_main_nxt, w_skid_nxt;
  issue_entry_t w_in_entry, w_main_fwd, w_skid_fwd;
  logic [XLEN-1:0] w_in_rs1, w_in_rs2, w_main_rs1, w_main_rs2, w_skid_rs1, w_skid_rs2;
  logic [XLEN-1:0] w_a, w_b;
  logic         w_in_xfer, w_out_xfer;

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_in_rs1 (
    .i_fwd_en(fwd_en), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
    .i_rs_addr(in_rs1_addr), .i_rs_val(in_rs1_val), .o_rs_val(w_in_rs1));
  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_in_rs2 (
    .i_fwd_en(fwd_en), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
    .i_rs_addr(in_rs2_addr), .i_rs_val(in_rs2_val), .o_rs_val(w_in_rs2));
  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_main_rs1 (
    .i_fwd_en(fwd_en), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
    .i_rs_addr(r_main.rs1_addr), .i_rs_val(r_main.rs1_val), .o_rs_val(w_main_rs1));
  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_main_rs2 (
    .i_fwd_en(fwd_en), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
    .i_rs_addr(r_main.rs2_addr), .i_rs_val(r_main.rs2_val), .o_rs_val(w_main_rs2));
  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_skid_rs1 (
    .i_fwd_en(fwd_en), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
    .i_rs_addr(r_skid.rs1_addr), .i_rs_val(r_skid.rs1_val), .o_rs_val(w_skid_rs1));
  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_skid_rs2 (
    .i_fwd_en(fwd_en), .i_fwd_rd(fwd_rd), .i_fwd_data(fwd_data),
    .i_rs_addr(r_skid.rs2_addr), .i_rs_val(r_skid.rs2_val), .o_rs_val(w_skid_rs2));

  always_comb begin
    w_in_entry          = '0;
    w_in_entry.funct3   = in_funct3;
    w_in_entry.alt      = in_alt;
    w_in_entry.branch   = in_branch;
    w_in_entry.use_imm  = in_use_imm;
    w_in_entry.use_pc   = in_use_pc;
    w_in_entry.rs1_addr = in_rs1_addr;
    w_in_entry.rs2_addr = in_rs2_addr;
    w_in_entry.rs1_val  = w_in_rs1;
    w_in_entry.rs2_val  = w_in_rs2;
    w_in_entry.imm      = in_imm;
    w_in_entry.pc       = in_pc;
    w_in_entry.rd       = in_rd;

    // Held entries keep absorbing write-backs so a stall never misses one.
    w_main_fwd          = r_main;
    w_main_fwd.rs1_val  = w_main_rs1;
    w_main_fwd.rs2_val  = w_main_rs2;
    w_skid_fwd          = r_skid;
    w_skid_fwd.rs1_val  = w_skid_rs1;
    w_skid_fwd.rs2_val  = w_skid_rs2;
  end

  assign out_valid  = (r_state != ST_EMPTY);
  assign in_ready   = r_in_ready;
  assign w_in_xfer  = in_valid && r_in_ready && !flush;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = w_main_fwd;
    w_skid_nxt  = w_skid_fwd;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_MAIN;
            w_main_nxt  = w_in_entry;
          end
        end
        ST_MAIN: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = w_in_entry;
          end else if (w_in_xfer) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = w_in_entry;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_state_nxt = ST_MAIN;
            w_main_nxt  = w_skid_fwd;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    r_main <= w_main_nxt;
    r_skid <= w_skid_nxt;
  end

  // Data outputs are forced to zero whenever no op is presented.
  always_comb begin
    w_a        = r_main.use_pc  ? r_main.pc  : r_main.rs1_val;
    w_b        = r_main.use_imm ? r_main.imm : r_main.rs2_val;
    alu_opsel  = '0;
    alu_alt    = 1'b0;
    alu_branch = 1'b0;
    alu_op1    = '0;
    alu_op2    = '0;
    out_rd     = '0;
    out_pc     = '0;
    if (out_valid) begin
      alu_opsel  = r_main.funct3;
      alu_branch = r_main.branch;
      alu_alt    = r_main.alt && !r_main.branch && alt_allowed(r_main.funct3);
      out_rd     = r_main.rd;
      out_pc     = r_main.pc;
      if (r_main.branch) begin
        alu_op1 = r_main.rs1_val;
        alu_op2 = r_main.rs2_val;
      end else if (swap_ops(r_main.funct3)) begin
        alu_op1 = w_b;
        alu_op2 = w_a;
      end else begin
        alu_op1 = w_a;
        alu_op2 = w_b;
      end
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed literal cases plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic        in_alt, in_branch, in_use_imm, in_use_pc;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd, fwd_rd, out_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc, fwd_data;
  logic        fwd_en, out_valid, out_ready, alu_alt, alu_branch;
  logic [2:0]  alu_opsel;
  logic [31:0] alu_op1, alu_op2, out_pc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        alt, br, uimm, upc;
    logic [4:0]  rs1a, rs2a, rd;
    logic [31:0] rs1v, rs2v, imm, pc;
  } ent_t;

  ent_t q[$];
  ent_t m_tmp;
  logic zero_chk = 1'b0;

  ex_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_branch(in_branch), .in_use_imm(in_use_imm),
    .in_use_pc(in_use_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
    .in_rd(in_rd), .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opsel(alu_opsel), .alu_alt(alu_alt),
    .alu_branch(alu_branch), .alu_op1(alu_op1), .alu_op2(alu_op2), .out_rd(out_rd),
    .out_pc(out_pc));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fsel(input logic en, input logic [4:0] rd,
                                       input logic [31:0] data, input logic [4:0] a,
                                       input logic [31:0] v);
    return (en && rd == a && a != 5'd0) ? data : v;
  endfunction

  function automatic logic [31:0] exp_op(input ent_t e, input bit second);
    logic [31:0] a, b;
    logic        sw;
    if (e.br) return second ? e.rs2v : e.rs1v;
    a  = e.upc  ? e.pc  : e.rs1v;
    b  = e.uimm ? e.imm : e.rs2v;
    sw = (e.f3 == 3'd1) || (e.f3 == 3'd5) || (e.f3 == 3'd2) || (e.f3 == 3'd3);
    if (sw) return second ? a : b;
    return second ? b : a;
  endfunction

  // Reference model: a FIFO of at most two ops, refreshed by write-back.
  always @(posedge clk) begin : model
    logic in_x, out_x;
    if (!rst_n) begin
      q.delete();
      zero_chk = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      in_x  = in_valid && (q.size() < 2);
      out_x = (q.size() > 0) && out_ready;
      for (int i = 0; i < q.size(); i++) begin
        m_tmp      = q[i];
        m_tmp.rs1v = fsel(fwd_en, fwd_rd, fwd_data, m_tmp.rs1a, m_tmp.rs1v);
        m_tmp.rs2v = fsel(fwd_en, fwd_rd, fwd_data, m_tmp.rs2a, m_tmp.rs2v);
        q[i]       = m_tmp;
      end
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        m_tmp.f3   = in_funct3;   m_tmp.alt  = in_alt;     m_tmp.br  = in_branch;
        m_tmp.uimm = in_use_imm;  m_tmp.upc  = in_use_pc;  m_tmp.rd  = in_rd;
        m_tmp.rs1a = in_rs1_addr; m_tmp.rs2a = in_rs2_addr;
        m_tmp.rs1v = fsel(fwd_en, fwd_rd, fwd_data, in_rs1_addr, in_rs1_val);
        m_tmp.rs2v = fsel(fwd_en, fwd_rd, fwd_data, in_rs2_addr, in_rs2_val);
        m_tmp.imm  = in_imm;      m_tmp.pc   = in_pc;
        q.push_back(m_tmp);
        zero_chk = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    ent_t e;
    chk("out_valid", out_valid, (q.size() > 0));
    chk("in_ready", in_ready, (q.size() < 2));
    if (q.size() > 0) begin
      e = q[0];
      chk("alu_op1", alu_op1, exp_op(e, 1'b0));
      chk("alu_op2", alu_op2, exp_op(e, 1'b1));
      chk("alu_opsel", alu_opsel, e.f3);
      chk("alu_branch", alu_branch, e.br);
      chk("alu_alt", alu_alt, (!e.br && (e.f3 == 3'd0 || e.f3 == 3'd5)) ? e.alt : 1'b0);
      chk("out_rd", out_rd, e.rd);
      chk("out_pc", out_pc, e.pc);
    end else if (zero_chk) begin
      chk("rst_op1", alu_op1, 0);
      chk("rst_op2", alu_op2, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_rd", out_rd, 0);
    end
  end

  task automatic drive_op(input logic [2:0] f3, input logic alt, input logic br,
                          input logic uimm, input logic upc, input logic [4:0] r1a,
                          input logic [4:0] r2a, input logic [31:0] r1v, input logic [31:0] r2v,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    in_valid = 1'b1; in_funct3 = f3; in_alt = alt; in_branch = br;
    in_use_imm = uimm; in_use_pc = upc; in_rs1_addr = r1a; in_rs2_addr = r2a;
    in_rs1_val = r1v; in_rs2_val = r2v; in_imm = imm; in_pc = pc; in_rd = rd;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; fwd_en = 1'b0; fwd_rd = '0; fwd_data = '0;
    drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (3) nxt();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    rst_n = 1'b1;

    // ADD, SLLI, SLT, SRA, XOR-with-alt, AUIPC
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'h100, 5'd3);
    nxt();
    chk("t1_valid", out_valid, 1); chk("t1_opsel", alu_opsel, 0);
    chk("t1_op1", alu_op1, 5); chk("t1_op2", alu_op2, 7); chk("t1_alt", alu_alt, 0);
    drive_op(3'd1, 0, 0, 1, 0, 5'd1, 5'd0, 32'h1, 32'd0, 32'd3, 32'h104, 5'd1);
    nxt();
    chk("slli_op1", alu_op1, 3); chk("slli_op2", alu_op2, 1);
    drive_op(3'd2, 0, 0, 0, 0, 5'd1, 5'd2, 32'd2, 32'd9, 32'd0, 32'h108, 5'd4);
    nxt();
    chk("slt_op1", alu_op1, 9); chk("slt_op2", alu_op2, 2);
    drive_op(3'd5, 1, 0, 1, 0, 5'd1, 5'd0, 32'h8000_0000, 32'd0, 32'd4, 32'h10c, 5'd5);
    nxt();
    chk("sra_op1", alu_op1, 4); chk("sra_op2", alu_op2, 32'h8000_0000); chk("sra_alt", alu_alt, 1);
    drive_op(3'd4, 1, 0, 0, 0, 5'd1, 5'd2, 32'hF0, 32'h0F, 32'd0, 32'h110, 5'd6);
    nxt();
    chk("xor_alt", alu_alt, 0); chk("xor_op1", alu_op1, 32'hF0); chk("xor_op2", alu_op2, 32'h0F);
    drive_op(3'd0, 0, 0, 1, 1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1000, 32'h200, 5'd7);
    nxt();
    chk("auipc_op1", alu_op1, 32'h200); chk("auipc_op2", alu_op2, 32'h1000);
    in_valid = 1'b0;
    nxt();

    // Backpressure: fill to FULL, third op held off, drain in order
    out_ready = 1'b0;
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd0, 32'h11, 32'd0, 32'd0, 32'h300, 5'd1);
    nxt(); chk("bp_ready1", in_ready, 1); chk("bp_a", alu_op1, 32'h11);
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd0, 32'h22, 32'd0, 32'd0, 32'h304, 5'd2);
    nxt(); chk("bp_ready2", in_ready, 0); chk("bp_a_hold", alu_op1, 32'h11);
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd0, 32'h33, 32'd0, 32'd0, 32'h308, 5'd3);
    nxt(); chk("bp_ready3", in_ready, 0); chk("bp_a_hold2", alu_op1, 32'h11);
    out_ready = 1'b1;
    nxt(); chk("bp_b", alu_op1, 32'h22); chk("bp_b_rd", out_rd, 2);
    nxt(); chk("bp_c", alu_op1, 32'h33); chk("bp_c_rd", out_rd, 3);
    in_valid = 1'b0;
    nxt(); chk("bp_drained", out_valid, 0);

    // Forwarding into a stalled op, x0 never forwarded, forwarding at capture
    out_ready = 1'b0;
    drive_op(3'd0, 0, 0, 0, 0, 5'd4, 5'd5, 32'h1111, 32'd0, 32'd0, 32'h400, 5'd1);
    nxt(); chk("fwd_before", alu_op1, 32'h1111);
    in_valid = 1'b0; fwd_en = 1'b1; fwd_rd = 5'd4; fwd_data = 32'hDEAD;
    nxt(); chk("fwd_stalled", alu_op1, 32'hDEAD);
    fwd_en = 1'b0; out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    drive_op(3'd0, 0, 0, 0, 0, 5'd0, 5'd5, 32'd5, 32'd0, 32'd0, 32'h404, 5'd1);
    fwd_en = 1'b1; fwd_rd = 5'd0; fwd_data = 32'hBEEF;
    nxt(); chk("fwd_x0_cap", alu_op1, 5);
    in_valid = 1'b0;
    nxt(); chk("fwd_x0_held", alu_op1, 5);
    out_ready = 1'b1; fwd_en = 1'b0;
    nxt();
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd6, 32'd0, 32'd1, 32'd0, 32'h408, 5'd1);
    fwd_en = 1'b1; fwd_rd = 5'd6; fwd_data = 32'h66;
    nxt(); chk("fwd_capture", alu_op2, 32'h66);
    in_valid = 1'b0; fwd_en = 1'b0;
    nxt();

    // Flush while FULL with a same-cycle push
    out_ready = 1'b0;
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd0, 32'hA1, 32'd0, 32'd0, 32'h500, 5'd1);
    nxt();
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd0, 32'hA2, 32'd0, 32'd0, 32'h504, 5'd2);
    nxt(); chk("fl_full", in_ready, 0);
    flush = 1'b1;
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd0, 32'hA3, 32'd0, 32'd0, 32'h508, 5'd3);
    nxt(); chk("fl_valid", out_valid, 0); chk("fl_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0;
    nxt(); chk("fl_gone", out_valid, 0);

    // Reset while FULL, then a branch compare
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd0, 32'hB1, 32'd0, 32'd0, 32'h600, 5'd1);
    nxt();
    drive_op(3'd0, 0, 0, 0, 0, 5'd1, 5'd0, 32'hB2, 32'd0, 32'd0, 32'h604, 5'd2);
    nxt(); chk("rs_full", in_ready, 0);
    in_valid = 1'b0; rst_n = 1'b0;
    nxt();
    chk("rs_valid", out_valid, 0); chk("rs_op1", alu_op1, 0);
    chk("rs_op2", alu_op2, 0); chk("rs_ready", in_ready, 1);
    rst_n = 1'b1; out_ready = 1'b1;
    drive_op(3'd0, 0, 1, 0, 0, 5'd1, 5'd2, 32'd3, 32'd3, 32'd0, 32'h700, 5'd0);
    nxt();
    chk("beq_branch", alu_branch, 1); chk("beq_opsel", alu_opsel, 0);
    chk("beq_op1", alu_op1, 3); chk("beq_op2", alu_op2, 3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 39) == 0);
      rst_n       = ($urandom_range(0, 199) != 0);
      in_funct3   = 3'($urandom_range(0, 7));
      in_alt      = 1'($urandom_range(0, 1));
      in_branch   = ($urandom_range(0, 3) == 0);
      in_use_imm  = 1'($urandom_range(0, 1));
      in_use_pc   = ($urandom_range(0, 3) == 0);
      in_rs1_addr = 5'($urandom_range(0, 7));
      in_rs2_addr = 5'($urandom_range(0, 7));
      in_rd       = 5'($urandom_range(0, 31));
      in_rs1_val  = $urandom; in_rs2_val = $urandom;
      in_imm      = $urandom; in_pc      = $urandom;
      fwd_en      = 1'($urandom_range(0, 1));
      fwd_rd      = 5'($urandom_range(0, 7));
      fwd_data    = $urandom;
      nxt();
    end
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1; fwd_en = 1'b0;
    repeat (4) nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
